ahb_arbiter: RTL and testbench



---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/rr_pick.sv | 34 +++
 rtl/ahb_arbiter.sv | 130 +++++++++++++
 tb/tb_ahb_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the masters, arbiter and address decoder.
// burst_beats() gives the number of beats that follow the NONSEQ of a fixed-length burst.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htran_t;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_t;

    // Zero means SINGLE or undefined-length INCR, i.e. no fixed beat count.
    function automatic logic [3:0] burst_beats(hburst_t b);
        case (b)
            WRAP4,  INCR4:  return 4'd3;
            WRAP8,  INCR8:  return 4'd7;
            WRAP16, INCR16: return 4'd15;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: first set request strictly after ptr,
// wrapping around so that ptr itself has the lowest priority.
module rr_pick #(
    parameter int NM = 4,
    parameter int MW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [MW-1:0] ptr,
    output logic [NM-1:0] gnt,
    output logic [MW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < NM; j++) begin
            if (!any && req[j] && (j > int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = MW'(j);
            end
        end
        for (int j = 0; j < NM; j++) begin
            if (!any && req[j] && (j <= int'(ptr))) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = MW'(j);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter for the LCD subsystem bus: fixed bursts are handed over
// on their second-to-last beat, locked sequences are kept, and error/retry/split opens the bus early.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NM             = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MW             = $clog2(NM)
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [NM-1:0] HBUSREQ,
    input  logic [NM-1:0] HLOCK,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HBURST,
    input  logic          HREADY,
    input  logic [1:0]    HRESP,
    output logic [NM-1:0] HGRANT,
    output logic [MW-1:0] HMASTER,
    output logic          HMASTLOCK
);

    localparam logic [NM-1:0] DEF_GNT = NM'(1) << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    logic [NM-1:0] r_grant;
    logic [MW-1:0] r_gnt_idx;
    logic [MW-1:0] r_master;
    logic          r_mastlock;
    logic [MW-1:0] r_rr_ptr;
    logic [3:0]    r_beat_cnt;
    logic          r_err_pend;

    htran_t        w_trans;
    hburst_t       w_burst;
    logic          w_fixed;
    logic          w_resp_bad;
    logic          w_arb_fixed;
    logic          w_arb_free;
    logic          w_arb_err;
    logic          w_arb_ok;
    logic          w_keep;
    logic [NM-1:0] w_req_others;
    logic [NM-1:0] w_req_eff;
    logic [NM-1:0] w_pick_gnt;
    logic [MW-1:0] w_pick_idx;
    logic          w_pick_any;

    assign w_trans    = htran_t'(HTRANS);
    assign w_burst    = hburst_t'(HBURST);
    assign w_fixed    = (burst_beats(w_burst) != 4'd0);
    assign w_resp_bad = (hresp_t'(HRESP) != OKAY);

    assign w_arb_fixed = HREADY && (w_trans == SEQ) && (r_beat_cnt == 4'd2);
    assign w_arb_free  = HREADY && (r_beat_cnt == 4'd0) &&
                         ((w_trans == IDLE) ||
                          (((w_trans == NONSEQ) || (w_trans == SEQ)) && !w_fixed));
    // After an error the owner may abandon its burst, so the burst type no longer pins the grant.
    assign w_arb_err   = HREADY && r_err_pend && (w_trans != BUSY) &&
                         !((w_trans == NONSEQ) && w_fixed);
    assign w_arb_ok    = w_arb_fixed || w_arb_free || w_arb_err;

    assign w_keep = HLOCK[r_gnt_idx] && HBUSREQ[r_gnt_idx];

    // The current owner competes only when nobody else is asking.
    assign w_req_others = HBUSREQ & ~r_grant;
    assign w_req_eff    = (|w_req_others) ? w_req_others : HBUSREQ;

    rr_pick #(
        .NM (NM),
        .MW (MW)
    ) u_rr_pick (
        .req (w_req_eff),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_grant    <= DEF_GNT;
            r_gnt_idx  <= DEF_IDX;
            r_master   <= DEF_IDX;
            r_mastlock <= 1'b0;
            r_rr_ptr   <= DEF_IDX;
            r_beat_cnt <= 4'd0;
            r_err_pend <= 1'b0;
        end else begin
            if (HREADY) begin
                r_master   <= r_gnt_idx;
                r_mastlock <= HLOCK[r_gnt_idx];
            end

            if (!HREADY && w_resp_bad) begin
                r_beat_cnt <= 4'd0;
                r_err_pend <= 1'b1;
            end else if (HREADY) begin
                r_err_pend <= 1'b0;
                case (w_trans)
                    NONSEQ:  r_beat_cnt <= burst_beats(w_burst);
                    SEQ:     if (r_beat_cnt != 4'd0) r_beat_cnt <= r_beat_cnt - 4'd1;
                    IDLE:    r_beat_cnt <= 4'd0;
                    default: r_beat_cnt <= r_beat_cnt;
                endcase
            end

            if (w_arb_ok) begin
                if (w_keep) begin
                    r_rr_ptr <= r_gnt_idx;
                end else if (w_pick_any) begin
                    r_grant   <= w_pick_gnt;
                    r_gnt_idx <= w_pick_idx;
                    r_rr_ptr  <= w_pick_idx;
                end else begin
                    r_grant   <= DEF_GNT;
                    r_gnt_idx <= DEF_IDX;
                end
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (HRESET) $onehot(HGRANT));
    a_master_range: assert property (@(posedge HCLK) disable iff (HRESET) int'(HMASTER) < NM);

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, fixed-burst handover with waits/BUSY,
// round-robin order, locked ownership, error re-arbitration and async reset.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    logic       HCLK;
    logic       HRESET;
    logic [3:0] HBUSREQ;
    logic [3:0] HLOCK;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [1:0] HRESP;
    logic [3:0] HGRANT;
    logic [1:0] HMASTER;
    logic       HMASTLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_arbiter #(
        .NM             (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HBUSREQ   (HBUSREQ),
        .HLOCK     (HLOCK),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HGRANT    (HGRANT),
        .HMASTER   (HMASTER),
        .HMASTLOCK (HMASTLOCK)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input htran_t trans,
                         input hburst_t burst, input logic ready, input hresp_t resp);
        HBUSREQ = req;
        HLOCK   = lock;
        HTRANS  = trans;
        HBURST  = burst;
        HREADY  = ready;
        HRESP   = resp;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // One bus cycle with master requests fixed, then check grant and owner.
    task automatic cyc(input string tag, input logic [3:0] req, input htran_t trans,
                       input hburst_t burst, input logic ready, input hresp_t resp,
                       input logic [3:0] exp_gnt, input logic [1:0] exp_mst);
        drive(req, 4'b0000, trans, burst, ready, resp);
        tick();
        check_eq({tag, "_gnt"}, HGRANT, exp_gnt);
        check_eq({tag, "_mst"}, HMASTER, exp_mst);
    endtask

    initial begin
        HRESET = 1'b1;
        drive(4'b0110, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        tick();
        check_eq("rst_gnt", HGRANT, 4'b0001);
        check_eq("rst_mst", HMASTER, 2'd0);
        check_eq("rst_lock", HMASTLOCK, 1'b0);

        // Idle bus: grant at the first edge, owner one edge later.
        HRESET = 1'b0;
        tick();
        check_eq("idle_gnt1", HGRANT, 4'b0010);
        check_eq("idle_mst1", HMASTER, 2'd0);
        HBUSREQ = 4'b0010;
        tick();
        check_eq("idle_gnt2", HGRANT, 4'b0010);
        check_eq("idle_mst2", HMASTER, 2'd1);

        // INCR8 by master 1, master 2 waiting: handover at the edge ending beat 7.
        for (int b = 1; b <= 8; b++) begin
            cyc($sformatf("incr8_b%0d", b), 4'b0110, (b == 1) ? NONSEQ : SEQ, INCR8, 1'b1, OKAY,
                (b >= 7) ? 4'b0100 : 4'b0010, (b == 8) ? 2'd2 : 2'd1);
        end
        cyc("m2_single", 4'b0100, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("m2_idle",   4'b0100, IDLE,   SINGLE, 1'b1, OKAY, 4'b0100, 2'd2);

        // INCR8 by master 2 with 3 wait states on beat 4 and a BUSY at beat_cnt=2.
        cyc("w_b1",    4'b1100, NONSEQ, INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b2",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b3",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b4w1",  4'b1100, SEQ,    INCR8, 1'b0, OKAY, 4'b0100, 2'd2);
        cyc("w_b4w2",  4'b1100, SEQ,    INCR8, 1'b0, OKAY, 4'b0100, 2'd2);
        cyc("w_b4w3",  4'b1100, SEQ,    INCR8, 1'b0, OKAY, 4'b0100, 2'd2);
        cyc("w_b4",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b5",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b6",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_busy",  4'b1100, BUSY,   INCR8, 1'b1, OKAY, 4'b0100, 2'd2);
        cyc("w_b7",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b1000, 2'd2);
        cyc("w_b8",    4'b1100, SEQ,    INCR8, 1'b1, OKAY, 4'b1000, 2'd3);

        // Masters 0, 1, 3 issuing SINGLEs: round-robin 0,1,3 repeating; 2 never granted.
        cyc("rr_1", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0001, 2'd3);
        cyc("rr_2", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0010, 2'd0);
        cyc("rr_3", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b1000, 2'd1);
        cyc("rr_4", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0001, 2'd3);
        cyc("rr_5", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0010, 2'd0);
        cyc("rr_6", 4'b1011, NONSEQ, SINGLE, 1'b1, OKAY, 4'b1000, 2'd1);

        // Master 3 locked INCR with master 0 requesting: ownership is kept.
        for (int c = 0; c < 4; c++) begin
            drive(4'b1001, 4'b1000, (c == 0) ? NONSEQ : SEQ, INCR, 1'b1, OKAY);
            tick();
            check_eq($sformatf("lock_gnt%0d", c), HGRANT, 4'b1000);
            check_eq($sformatf("lock_mst%0d", c), HMASTER, 2'd3);
            check_eq($sformatf("lock_ml%0d", c), HMASTLOCK, 1'b1);
        end
        drive(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        tick();
        check_eq("unlock_gnt", HGRANT, 4'b0001);
        check_eq("unlock_mst", HMASTER, 2'd3);
        check_eq("unlock_ml", HMASTLOCK, 1'b0);
        tick();
        check_eq("unlock_mst2", HMASTER, 2'd0);
        check_eq("unlock_ml2", HMASTLOCK, 1'b0);

        // ERROR on INCR4 beat 2: the second response cycle is a free arbitration point.
        cyc("err_b1",  4'b0011, NONSEQ, INCR4, 1'b1, OKAY,  4'b0001, 2'd0);
        cyc("err_c1",  4'b0011, SEQ,    INCR4, 1'b0, ERROR, 4'b0001, 2'd0);
        cyc("err_c2",  4'b0011, SEQ,    INCR4, 1'b1, ERROR, 4'b0010, 2'd0);
        cyc("err_idl", 4'b0010, IDLE,   SINGLE, 1'b1, OKAY, 4'b0010, 2'd1);

        // Asynchronous reset mid-burst.
        cyc("ar_b1", 4'b0110, NONSEQ, INCR4, 1'b1, OKAY, 4'b0010, 2'd1);
        cyc("ar_b2", 4'b0110, SEQ,    INCR4, 1'b1, OKAY, 4'b0010, 2'd1);
        #2;
        HRESET = 1'b1;
        #1;
        check_eq("arst_gnt", HGRANT, 4'b0001);
        check_eq("arst_mst", HMASTER, 2'd0);
        check_eq("arst_ml", HMASTLOCK, 1'b0);
        tick();
        HRESET = 1'b0;
        drive(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY);
        tick();
        check_eq("post_rst_gnt", HGRANT, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
